dropout_mask_gen: RTL and testbench

Synthesizable pseudo-random keep-mask generator that sits directly upstream of the dropout stage and replaces simulation-only random calls. A 16-bit Galois LFSR produces one lane decision per cycle. The decisions are compared against a programmable 8-bit drop rate and assembled into an 8-lane keep-mask. The mask is then presented to the dropout stage through a valid/ready handshake.

---
 rtl/dropout_mask_gen.sv | 135 +++++++++++++
 tb/tb_dropout_mask_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dropout_mask_gen.sv
// dropout_mask_gen: 16-bit Galois LFSR driving an 8-lane keep-mask, one lane per cycle, valid/ready output.
// Optional feature macro DROPOUT_MASK_AUTO_EN: each completed handshake re-enters GEN reusing the latched rate.
module dropout_mask_gen #(
   parameter int unsigned LANES = 8,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             seed_load,
   input  logic [15:0]      seed_in,
   input  logic [7:0]       rate,
   input  logic             start,
   input  logic             mask_ready,
   output logic             mask_valid,
   output logic [LANES-1:0] mask,
   output logic [3:0]       drop_cnt,
   output logic             busy
);

   localparam int unsigned CNT_W    = $clog2(LANES);
   localparam logic [15:0] POLY_TAP = 16'hB400;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GEN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t             state_q;
   logic [15:0]        lfsr_q;
   logic [15:0]        lfsr_d;
   logic [7:0]         rate_q;
   logic [7:0]         rate_d;
   logic [CNT_W-1:0]   lane_q;
   logic [LANES-1:0]   mask_q;
   logic [3:0]         drop_cnt_q;
   logic               mask_valid_q;
   logic               busy_q;

   logic               lane_drop;
   logic               last_lane;
   logic               handshake;
   logic               restart;
   logic [15:0]        seed_eff;

   assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY_TAP : 16'h0000);
   assign lane_drop = (lfsr_q[7:0] < rate_q);
   assign last_lane = (lane_q == CNT_W'(LANES - 1));
   assign handshake = mask_valid_q & mask_ready;
   // A zero seed would lock the LFSR at zero forever, so it is replaced.
   assign seed_eff  = (seed_in == 16'h0000) ? SEED : seed_in;
   assign rate_d    = start ? rate : rate_q;

`ifdef DROPOUT_MASK_AUTO_EN
   assign restart = 1'b1;
`else
   assign restart = start;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         lfsr_q       <= SEED;
         rate_q       <= 8'h00;
         lane_q       <= '0;
         mask_q       <= '0;
         drop_cnt_q   <= 4'd0;
         mask_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else if (seed_load) begin
         state_q      <= S_IDLE;
         lfsr_q       <= seed_eff;
         lane_q       <= '0;
         mask_q       <= '0;
         drop_cnt_q   <= 4'd0;
         mask_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_GEN;
                  rate_q     <= rate;
                  lane_q     <= '0;
                  mask_q     <= '0;
                  drop_cnt_q <= 4'd0;
                  busy_q     <= 1'b1;
               end
            end
            S_GEN: begin
               if (ena) begin
                  lfsr_q         <= lfsr_d;
                  mask_q[lane_q] <= ~lane_drop;
                  if (lane_drop) begin
                     drop_cnt_q <= drop_cnt_q + 4'd1;
                  end
                  lane_q <= lane_q + CNT_W'(1);
                  if (last_lane) begin
                     state_q      <= S_HOLD;
                     mask_valid_q <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               // A start in the handshake cycle chains straight into the next mask.
               if (handshake) begin
                  mask_valid_q <= 1'b0;
                  if (restart) begin
                     state_q    <= S_GEN;
                     rate_q     <= rate_d;
                     lane_q     <= '0;
                     mask_q     <= '0;
                     drop_cnt_q <= 4'd0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q      <= S_IDLE;
               mask_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign mask_valid = mask_valid_q;
   assign mask       = mask_q;
   assign drop_cnt   = drop_cnt_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Self-checking bench for dropout_mask_gen: directed sequence with randomized seeds/rates against a lane-by-lane model.
// Honours DROPOUT_MASK_AUTO_EN where the post-handshake behaviour differs.
module tb_dropout_mask_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic        seed_load = 1'b0;
   logic [15:0] seed_in = 16'h0000;
   logic [7:0]  rate = 8'h00;
   logic        start = 1'b0;
   logic        mask_ready = 1'b0;
   logic        mask_valid;
   logic [7:0]  mask;
   logic [3:0]  drop_cnt;
   logic        busy;

   int          checks = 0;
   int          errors = 0;

   int          cyc;
   int          stable;
   int          seen;
   logic [15:0] s;
   logic [15:0] l1;
   logic [15:0] l2;
   logic [7:0]  r;
   logic [7:0]  r2;
   logic [7:0]  m1;
   logic [7:0]  m2;
   int          d1;
   int          d2;

   dropout_mask_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .rate       (rate),
      .start      (start),
      .mask_ready (mask_ready),
      .mask_valid (mask_valid),
      .mask       (mask),
      .drop_cnt   (drop_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the 8 lanes, comparing the low byte of the LFSR with the rate, then step it.
   function automatic void model_mask(input logic [15:0] seed, input logic [7:0] rt,
                                      output logic [7:0] m, output int drops,
                                      output logic [15:0] l_out);
      int unsigned l;
      l = (seed == 16'h0000) ? 32'hACE1 : 32'(seed);
      m = 8'h00;
      drops = 0;
      for (int k = 0; k < 8; k++) begin
         if ((l % 256) < 32'(rt)) drops++;
         else m[k] = 1'b1;
         l = (l / 2) ^ (((l % 2) == 1) ? 32'hB400 : 32'h0);
      end
      l_out = l[15:0];
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_seed(input logic [15:0] sv);
      seed_in = sv;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
   endtask

   // Returns the number of edges after the accepting edge until mask_valid is seen.
   task automatic start_wait(input logic [7:0] rt, input int stall_at, input int stall_len,
                             output int c);
      rate = rt;
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 0;
      while (!mask_valid && c < 40) begin
         ena = (c >= stall_at && c < stall_at + stall_len) ? 1'b0 : 1'b1;
         tick();
         c++;
      end
      ena = 1'b1;
   endtask

   task automatic handshake();
      mask_ready = 1'b1;
      tick();
      mask_ready = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_valid", 32'(mask_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mask", 32'(mask), 0);
      chk("rst_cnt", 32'(drop_cnt), 0);
      rst_n = 1'b1;
      tick();

      rate = 8'h55;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("gen_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(mask_valid), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_mask", 32'(mask), 0);
      chk("async_rst_cnt", 32'(drop_cnt), 0);
      tick();
      rst_n = 1'b1;
      tick();

      start_wait(8'h00, 99, 0, cyc);
      chk("rate0_lat", 32'(cyc), 8);
      chk("rate0_mask", 32'(mask), 32'hFF);
      chk("rate0_cnt", 32'(drop_cnt), 0);
      handshake();
      chk("hs_valid_low", 32'(mask_valid), 0);
`ifdef DROPOUT_MASK_AUTO_EN
      chk("hs_auto_busy", 32'(busy), 1);
`else
      chk("hs_idle_busy", 32'(busy), 0);
`endif

      do_seed(16'h0001);
      start_wait(8'h80, 99, 0, cyc);
      chk("vec_lat", 32'(cyc), 8);
      chk("vec_mask", 32'(mask), 32'hD0);
      chk("vec_cnt", 32'(drop_cnt), 5);
      handshake();

      do_seed(16'h0001);
      start_wait(8'hFF, 99, 0, cyc);
      chk("full_mask", 32'(mask), 32'h00);
      chk("full_cnt", 32'(drop_cnt), 8);
      handshake();

      r = 8'($urandom_range(1, 254));
      model_mask(16'h0000, r, m1, d1, l1);
      do_seed(16'h0000);
      start_wait(r, 99, 0, cyc);
      chk("zseed_mask", 32'(mask), 32'(m1));
      chk("zseed_cnt", 32'(drop_cnt), 32'(d1));
      handshake();

      for (int i = 0; i < 4; i++) begin
         s = 16'($urandom);
         r = 8'($urandom);
         model_mask(s, r, m1, d1, l1);
         do_seed(s);
         start_wait(r, 99, 0, cyc);
         chk("rnd_lat", 32'(cyc), 8);
         chk("rnd_mask", 32'(mask), 32'(m1));
         chk("rnd_cnt", 32'(drop_cnt), 32'(d1));
         handshake();
      end

      s = 16'($urandom);
      r = 8'($urandom);
      r2 = 8'($urandom);
      model_mask(s, r, m1, d1, l1);
      model_mask(l1, r2, m2, d2, l2);
      do_seed(s);
      start_wait(r, 99, 0, cyc);
      chk("bp_mask", 32'(mask), 32'(m1));
      stable = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            start = 1'b1;
            rate = ~r;
         end
         tick();
         start = 1'b0;
         if (!mask_valid || mask !== m1 || drop_cnt !== 4'(d1)) stable = 0;
      end
      chk("bp_stable", 32'(stable), 1);
      rate = r2;
      start = 1'b1;
      mask_ready = 1'b1;
      tick();
      start = 1'b0;
      mask_ready = 1'b0;
      cyc = 1;
      while (!mask_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("b2b_period", 32'(cyc), 9);
      chk("b2b_mask", 32'(mask), 32'(m2));
      chk("b2b_cnt", 32'(drop_cnt), 32'(d2));
      handshake();

      s = 16'($urandom);
      r = 8'($urandom_range(40, 220));
      model_mask(s, r, m1, d1, l1);
      do_seed(s);
      start_wait(r, 2, 3, cyc);
      chk("stall_lat", 32'(cyc), 11);
      chk("stall_mask", 32'(mask), 32'(m1));
      chk("stall_cnt", 32'(drop_cnt), 32'(d1));
      handshake();

      do_seed(s);
      rate = r;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      seed_in = s;
      seed_load = 1'b1;
      start = 1'b1;
      tick();
      seed_load = 1'b0;
      start = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(mask_valid), 0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (mask_valid || busy) seen = 1;
      end
      chk("abort_quiet", 32'(seen), 0);
      start_wait(r, 99, 0, cyc);
      chk("reload_mask", 32'(mask), 32'(m1));
      chk("reload_cnt", 32'(drop_cnt), 32'(d1));
      handshake();
`ifdef DROPOUT_MASK_AUTO_EN
      model_mask(l1, r, m2, d2, l2);
      chk("auto_busy", 32'(busy), 1);
      cyc = 0;
      while (!mask_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("auto_lat", 32'(cyc), 8);
      chk("auto_mask", 32'(mask), 32'(m2));
      do_seed(16'h0001);
      chk("auto_stop_busy", 32'(busy), 0);
`else
      chk("after_abort_idle", 32'(busy), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
